// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that shares one FIFO write port among NUM_REQ producers.
// A granted owner may burst up to MAX_BURST consecutive words.
// Ownership is released early when the owner drops its request.
// On release the arbiter re-arbitrates in the same cycle, so owner changes add no bubble.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  input  logic                          fifo_overflow,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic [CNT_WIDTH-1:0]          wr_count,
  output logic [CNT_WIDTH-1:0]          stall_count,
  output logic                          err_overflow
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt, owner_nxt;
  logic [3:0]       burst_cnt, burst_cnt_nxt;
  logic [IDX_W-1:0] arb_start, pick_idx, grant_idx;
  logic             pick_vld, grant_vld, do_arb;

  // Index after i, wrapping at NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // First set request bit searching upward from start, modulo NUM_REQ.
  function automatic logic [IDX_W:0] find_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   start);
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   res;
    res = '0;
    idx = start;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!res[IDX_W] && r[idx]) res = {1'b1, idx};
      idx = next_idx(idx);
    end
    return res;
  endfunction

  // Next-state, grant decision and bookkeeping for the owner and round-robin pointer.
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    owner_nxt     = owner;
    burst_cnt_nxt = burst_cnt;
    grant_vld     = 1'b0;
    grant_idx     = owner;
    do_arb        = 1'b0;
    // A releasing owner searches from owner+1 so it only wins again when it is the sole requester.
    arb_start     = (state == BURST) ? next_idx(owner) : rr_ptr;
    {pick_vld, pick_idx} = find_pick(req, arb_start);

    case (state)
      IDLE: do_arb = 1'b1;
      BURST: begin
        if (req[owner] && (burst_cnt < 4'(MAX_BURST))) begin
          // A full FIFO only stalls the owner; ownership is kept.
          if (!fifo_full) begin
            grant_vld     = 1'b1;
            burst_cnt_nxt = burst_cnt + 4'd1;
          end
        end else begin
          rr_ptr_nxt = next_idx(owner);
          state_nxt  = IDLE;
          do_arb     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (do_arb && pick_vld && !fifo_full) begin
      grant_vld = 1'b1;
      grant_idx = pick_idx;
      owner_nxt = pick_idx;
      if (MAX_BURST == 1) begin
        rr_ptr_nxt = next_idx(pick_idx);
      end else begin
        state_nxt     = BURST;
        burst_cnt_nxt = 4'd1;
      end
    end

    if (rst) grant_vld = 1'b0;
  end

  // Grant vector and FIFO write-side drive.
  always_comb begin
    gnt          = '0;
    fifo_data_in = '0;
    if (grant_vld) begin
      gnt[grant_idx] = 1'b1;
      fifo_data_in   = req_data[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
    end
    fifo_wr_en = |gnt;
  end

  assign busy = (state == BURST);

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Statistics counters and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count     <= '0;
      stall_count  <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (fifo_wr_en) wr_count <= wr_count + 1'b1;
      if ((|req) && fifo_full) stall_count <= stall_count + 1'b1;
      if (fifo_overflow) err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a driver applies stimulus and pushes the
// expected cycle response from a behavioural model; a negedge monitor pops and compares.
module tb_fifo_wr_arbiter;

  localparam int DW = 8, NR = 4, MB = 4, CW = 16, DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     gnt;
  logic              fifo_full = 1'b0, fifo_overflow = 1'b0, fifo_wr_en;
  logic [DW-1:0]     fifo_data_in;
  logic              busy, err_overflow;
  logic [1:0]        owner;
  logic [CW-1:0]     wr_count, stall_count;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_overflow(fifo_overflow), .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in), .busy(busy), .owner(owner), .wr_count(wr_count),
    .stall_count(stall_count), .err_overflow(err_overflow));

  // Second instance with single-word bursts.
  logic              rst_b = 1'b1;
  logic [NR-1:0]     req_b = '0, gnt_b;
  logic [NR*DW-1:0]  req_data_b = 32'h44_33_22_11;
  logic              full_b = 1'b0, ovf_b = 1'b0, wr_en_b, busy_b, err_b;
  logic [DW-1:0]     data_b;
  logic [1:0]        owner_b;
  logic [CW-1:0]     wr_count_b, stall_count_b;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(1), .CNT_WIDTH(CW)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .req_data(req_data_b), .gnt(gnt_b),
    .fifo_full(full_b), .fifo_overflow(ovf_b), .fifo_wr_en(wr_en_b),
    .fifo_data_in(data_b), .busy(busy_b), .owner(owner_b), .wr_count(wr_count_b),
    .stall_count(stall_count_b), .err_overflow(err_b));

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [NR-1:0] gnt;
    logic [DW-1:0] data;
    logic          busy;
    logic [1:0]    owner;
    logic [CW-1:0] wr;
    logic [CW-1:0] stall;
    logic          err;
  } exp_t;

  exp_t sb[$];

  // Behavioural reference: who holds the port, for how long, where the search starts.
  bit            m_hold = 0;
  int            m_own = 0, m_run = 0, m_ptr = 0;
  logic [CW-1:0] m_wr = '0, m_stall = '0;
  bit            m_err = 0;
  int            fcount = 0;           // model FIFO occupancy
  int            seq[NR] = '{0, 0, 0, 0};

  function automatic logic [DW-1:0] word_of(input int i);
    return DW'(i * 64 + (seq[i] % 64));
  endfunction

  // One clock cycle of stimulus plus its expected response.
  task automatic step(input bit r, input logic [NR-1:0] rq, input bit rd, input bit ovf);
    exp_t e;
    int   g;
    bit   full_now, do_arb, rd_ok;
    @(posedge clk); #1;
    full_now      = (fcount >= DEPTH);
    rst           = r;
    req           = rq;
    fifo_overflow = ovf;
    fifo_full     = full_now;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = word_of(i);

    e.busy  = m_hold;
    e.owner = 2'(m_own);
    e.wr    = m_wr;
    e.stall = m_stall;
    e.err   = m_err;
    g = -1;
    if (!r) begin
      do_arb = 1;
      if (m_hold) begin
        if (rq[m_own] && m_run < MB) begin
          do_arb = 0;
          if (!full_now) begin g = m_own; m_run++; end
        end else begin
          m_ptr  = (m_own + 1) % NR;
          m_hold = 0;
        end
      end
      if (do_arb && rq != 0 && !full_now) begin
        for (int k = 0; k < NR; k++)
          if (g < 0 && rq[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        m_own = g;
        if (MB == 1) m_ptr = (g + 1) % NR;
        else begin m_hold = 1; m_run = 1; end
      end
    end
    e.gnt  = '0;
    e.data = '0;
    if (g >= 0) begin
      e.gnt[g] = 1'b1;
      e.data   = word_of(g);
    end
    sb.push_back(e);

    rd_ok = rd && (fcount > 0);
    if (r) begin
      m_hold = 0; m_own = 0; m_run = 0; m_ptr = 0;
      m_wr = '0; m_stall = '0; m_err = 0;
    end else begin
      if (g >= 0) begin m_wr++; fcount++; seq[g]++; end
      if (rq != 0 && full_now) m_stall++;
      if (ovf) m_err = 1;
    end
    if (rd_ok) fcount--;
  endtask

  // Monitor: compare the DUT's presented response against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("gnt", 32'(gnt), 32'(e.gnt));
      chk("wr_en", 32'(fifo_wr_en), 32'(|e.gnt));
      chk("data_in", 32'(fifo_data_in), 32'(e.data));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("owner", 32'(owner), 32'(e.owner));
      chk("wr_count", 32'(wr_count), 32'(e.wr));
      chk("stall_count", 32'(stall_count), 32'(e.stall));
      chk("err_overflow", 32'(err_overflow), 32'(e.err));
      if (fifo_wr_en && fifo_full) chk("wr_while_full", 32'(fifo_wr_en), 32'd0);
    end
  end

  // Single-word bursts: req 0101 held must alternate P0, P2 with busy low.
  initial begin
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    req_b = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("mb1_gnt", 32'(gnt_b), (k % 2 == 0) ? 32'h1 : 32'h4);
      chk("mb1_data", 32'(data_b), (k % 2 == 0) ? 32'h11 : 32'h33);
      chk("mb1_busy", 32'(busy_b), 32'd0);
      @(posedge clk); #1;
    end
    req_b = '0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    // Reset state.
    step(1, '0, 0, 0);
    step(1, 4'b1111, 0, 0);
    // Single producer fills the FIFO, then stalls on full.
    for (int i = 0; i < 36; i++) step(0, 4'b0001, 0, 0);
    for (int i = 0; i < 40; i++) step(0, '0, 1, 0);
    // All four requesting until full.
    for (int i = 0; i < 36; i++) step(0, 4'b1111, 0, 0);
    for (int i = 0; i < 40; i++) step(0, '0, 1, 0);
    // Early release: P1 takes two words, then drops while P3 waits.
    step(1, '0, 0, 0);
    step(0, 4'b1010, 0, 0);
    step(0, 4'b1010, 0, 0);
    step(0, 4'b1000, 0, 0);
    step(0, 4'b1000, 0, 0);
    step(0, '0, 0, 0);
    // Reset during P1's third grant, then P0 and P1 request.
    step(0, 4'b0010, 0, 0);
    step(0, 4'b0010, 0, 0);
    step(1, 4'b0010, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 4'b0011, 0, 0);
    // Sticky overflow flag.
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    // Full stall: fill to DEPTH-1, P2 wants words, reads release it.
    guard = 0;
    while (fcount < DEPTH - 1 && guard < 80) begin
      step(0, 4'b0001, 0, 0);
      guard++;
    end
    for (int i = 0; i < 4; i++) step(0, 4'b0100, 0, 0);
    step(0, 4'b0100, 1, 0);
    step(0, 4'b0100, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 4'b0100, 0, 0);
    for (int i = 0; i < 40; i++) step(0, '0, 1, 0);
    // Randomized traffic with random reads, occasional reset and overflow.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), NR'($urandom),
           ($urandom_range(0, 99) < ((i < 300) ? 40 : 70)),
           ($urandom_range(0, 99) == 0));
    end
    step(0, '0, 1, 0);
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `fifo` write port among `NUM_REQ` producers. Each producer presents a word with a level request; the arbiter grants one producer per cycle. It forwards the granted word to the FIFO's `wr_en`/`data_in`, never writes while the FIFO reports `full`, and lets an owner burst up to `MAX_BURST` consecutive words before rotating. It sits directly in front of the FIFO write side; the read side is untouched.

## Interface
- `DATA_WIDTH`, default 8: word width; matches the FIFO's `DATA_WIDTH`.
- `NUM_REQ`, default 4: number of producers, 2..8.
- `MAX_BURST`, default 4: maximum consecutive grants to one owner, 1..15.
- `CNT_WIDTH`, default 16: width of the statistics counters.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in NUM_REQ: per-producer request level; bit i covers producer i.
- `req_data` in NUM_REQ*DATA_WIDTH: producer i's word is in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `gnt` out NUM_REQ: one-hot or zero. While high, the word offered that cycle is accepted.
- `fifo_full` in 1: the FIFO's `full`.
- `fifo_overflow` in 1: the FIFO's `overflow`.
- `fifo_wr_en` out 1: drives the FIFO's `wr_en`.
- `fifo_data_in` out DATA_WIDTH: drives the FIFO's `data_in`.
- `busy` out 1: high while a burst owner is held.
- `owner` out $clog2(NUM_REQ): index of the current or last owner.
- `wr_count` out CNT_WIDTH: total accepted words.
- `stall_count` out CNT_WIDTH: number of cycles in which a request was pending but blocked by `fifo_full`.
- `err_overflow` out 1: sticky; set when `fifo_overflow` is seen high.

## Operation
- Handshake is valid/ready style within a single cycle:
  - `gnt` is combinational from the registered state, `req` and `fifo_full`.
  - A producer holds `req` and its data stable until it sees `gnt[i]` high at a clock edge.
  - It may drop `req` at any time when not granted.
- `fifo_wr_en = |gnt`.
- `fifo_data_in` = the granted producer's word, or all zeros when there is no grant.
- Hard rule: `fifo_wr_en` is never high while `fifo_full` or `rst` is high.
- The FSM has two states, IDLE and BURST, plus registers `rr_ptr`, `owner` and `burst_cnt` (4 bits).
- Arbitration pick: the first set `req` bit searching upward from `rr_ptr`, modulo NUM_REQ.
- In IDLE:
  - If `|req && !fifo_full`: grant the pick, set `owner` to the pick and `burst_cnt` to 1, and go to BURST.
  - If MAX_BURST == 1: stay in IDLE and set `rr_ptr` to pick+1 instead.
  - Otherwise no grant and no change.
- In BURST, one of three cases applies:
  - Continue, when `req[owner] && burst_cnt < MAX_BURST && !fifo_full`: grant `owner` and increment `burst_cnt`.
  - Stall, when `req[owner] && burst_cnt < MAX_BURST && fifo_full`: no grant; `owner`, `burst_cnt` and state are held.
  - Release, when `!req[owner] || burst_cnt == MAX_BURST`: set `rr_ptr` to owner+1 and re-arbitrate in the same cycle as in IDLE, so there is no bubble cycle. The old owner may win only if it is the sole requester.
- When `fifo_full` rises mid-burst, the owner keeps the port, so full never steals ownership.
- `wr_count` increments on every cycle with `fifo_wr_en` high.
- `stall_count` increments on every cycle with `|req && fifo_full`.
- Both counters wrap modulo 2^CNT_WIDTH.
- `err_overflow` is cleared only by `rst`.
- `busy` = (state == BURST).

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `owner` 0, `burst_cnt` 0, `busy` 0, `wr_count` 0, `stall_count` 0, `err_overflow` 0.
- While `rst` is high, `gnt` = 0, `fifo_wr_en` = 0 and `fifo_data_in` = 0, regardless of `req`.
- Grant latency is 0 cycles: a request raised before edge N, with FIFO not full and the arbiter free, is written at edge N.
- Sustained throughput is one word per cycle with no gaps across owner changes.
- `fifo_full` is sampled combinationally in the same cycle. A write in the cycle where the FIFO has one free slot is legal; `full` then rises after that edge and the next cycle is blocked.
- Reset mid-burst: the next cycle after reset deasserts is IDLE with `rr_ptr` = 0. The in-flight word is not granted, and its producer must keep `req` asserted.
- Simultaneous release and a new `fifo_full`: no grant that cycle, `rr_ptr` still advances, and the state goes to IDLE.
- `owner` and `busy` are registered; they update one edge after the grant decision.

## Test plan
- **Single producer.** After reset, `req` = 4'b0001 with data 0x00..0x1F incrementing on each grant. Required: 32 writes in 32 consecutive cycles, with bursts of 4 separated by release and immediate re-grant to producer 0. The FIFO reads back 0x00..0x1F, `wr_count` = 32, `full` = 1, `err_overflow` = 0.
- **All four requesting, MAX_BURST = 4.** `req` = 4'b1111 held. Required grant order: P0×4, P1×4, P2×4, P3×4, P0…, with `fifo_wr_en` continuously high until full.
- **Full stall.** Fill the FIFO to 31 entries, then P2 requests 3 words. Required:
  - One write, after which `full` = 1.
  - The following cycles show `gnt` = 0 and `stall_count` incrementing.
  - After 2 FIFO reads, P2 resumes without rotation; `owner` stays 2 throughout.
  - `overflow` is never set.
- **Early release.** P1 drops `req` after 2 grants while P3 is requesting. Required: P3 is granted in the same cycle P1 releases, with no idle cycle, and `rr_ptr` = 2 before the pick.
- **Reset mid-burst.** Assert `rst` for 1 cycle during P1's third grant. Required: no write in the reset cycle; all counters = 0; the next grant goes to P0 if it is requesting, otherwise to the lowest set bit.
- **MAX_BURST = 1.** `req` = 4'b0101 held. Required: grants alternate P0, P2, P0, P2…, and `busy` stays 0.
